// File: rtl/display_pkg.sv
// Shared types and helpers for the display scheduler and its round-robin picker.
package display_pkg;

  localparam int DISP_W  = 8;
  localparam int MAX_SRC = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  function automatic logic [MAX_SRC-1:0] onehot(input logic [2:0] idx);
    logic [MAX_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester/display bus between the sources and the display scheduler.
interface display_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int DW      = display_pkg::DISP_W
);

  localparam int IW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC*DW-1:0] data;
  logic [NUM_SRC-1:0]    grant;
  logic [DW-1:0]         disp_din;
  logic                  disp_en;
  logic                  busy;
  logic [IW-1:0]         cur_src;

  modport master (
    output req, data,
    input  grant, disp_din, disp_en, busy, cur_src
  );

  modport slave (
    input  req, data,
    output grant, disp_din, disp_en, busy, cur_src
  );

endinterface

// File: rtl/display_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_SRC.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  // The previous holder is scanned last, so it wins only when it is the sole requester.
  always_comb begin : scan
    int c;
    c      = 0;
    valid  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      c = (int'(last) + i) % NUM_SRC;
      if (!valid && req[c[IW-1:0]]) begin
        valid  = 1'b1;
        winner = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the seven-segment display between requesters with a round-robin hold scheme.
// Optional macro SRC0_PREEMPT_EN lets source 0 preempt any other source's hold.
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int DW          = DISP_W
) (
  input  logic               disp_clk,
  input  logic               rst_n,
  display_scheduler_if.slave bus
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      cur_src_q, cur_src_d;
  logic [DW-1:0]      din_q, din_d;
  logic               en_q, en_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic               preempt;
  logic               load;
  logic [IW-1:0]      load_idx;
  logic [MAX_SRC-1:0] load_oh;
  logic [DW-1:0]      src_val [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_val[i] = bus.data[DW*i +: DW];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef SRC0_PREEMPT_EN
  assign preempt = (state_q == SHOW) && (cur_src_q != '0) && bus.req[0];
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    cur_src_d = cur_src_q;
    din_d     = din_q;
    busy_d    = busy_q;
    grant_d   = '0;
    en_d      = 1'b0;
    load      = 1'b0;
    load_idx  = pick_idx;
    load_oh   = '0;

    case (state_q)
      IDLE: load = pick_valid;
      SHOW: begin
        if (preempt) begin
          load     = 1'b1;
          load_idx = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (pick_valid) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load samples the winner's data and restarts the full hold window.
    if (load) begin
      load_oh   = onehot(3'(load_idx));
      din_d     = src_val[load_idx];
      en_d      = 1'b1;
      grant_d   = load_oh[NUM_SRC-1:0];
      cur_src_d = load_idx;
      last_d    = load_idx;
      timer_d   = TW'(HOLD_CYCLES - 1);
      state_d   = SHOW;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge disp_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      last_q    <= IW'(NUM_SRC - 1);
      cur_src_q <= '0;
      din_q     <= '0;
      en_q      <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      cur_src_q <= cur_src_d;
      din_q     <= din_d;
      en_q      <= en_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.disp_din = din_q;
  assign bus.disp_en  = en_q;
  assign bus.busy     = busy_q;
  assign bus.cur_src  = cur_src_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: vector table, corner sequences, random vs model.
module tb_display_scheduler;
  import display_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int HOLD    = 4;
  localparam int DW      = 8;
  localparam logic [31:0] DATA = 32'h44_DB_22_11;

  typedef struct packed {
    logic [3:0] grant;
    logic       en;
    logic [7:0] din;
    logic       busy;
    logic [1:0] cur;
  } obs_t;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    obs_t       exp;
  } vec_t;

  logic disp_clk = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  bit         m_show;
  int         m_last;
  int         m_cur;
  logic [7:0] m_din;
  int         m_age;
  obs_t       m_exp;

  vec_t vecs[17];

  always #5 disp_clk = ~disp_clk;

  display_scheduler_if #(.NUM_SRC(NUM_SRC), .DW(DW)) bus ();

  display_scheduler #(
    .NUM_SRC     (NUM_SRC),
    .HOLD_CYCLES (HOLD),
    .DW          (DW)
  ) dut (
    .disp_clk (disp_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  function automatic obs_t mkObs(logic [3:0] g, logic e, logic [7:0] dn, logic b, logic [1:0] c);
    obs_t o;
    o.grant = g;
    o.en    = e;
    o.din   = dn;
    o.busy  = b;
    o.cur   = c;
    return o;
  endfunction

  function automatic vec_t mkVec(logic r, logic [3:0] q, obs_t e);
    vec_t v;
    v.rst_n = r;
    v.req   = q;
    v.exp   = e;
    return v;
  endfunction

  // Reference arbitration: first requester strictly after the previous holder, wrapping.
  function automatic int rrWinner(input logic [3:0] q, input int last);
    int c;
    for (int i = 1; i <= NUM_SRC; i++) begin
      c = (last + i) % NUM_SRC;
      if (q[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic r, input logic [3:0] q, input logic [31:0] d);
    bit          load;
    bit          pre;
    int          w;
    logic [31:0] t;
    load = 0;
    pre  = 0;
    w    = 0;
    m_exp.grant = '0;
    m_exp.en    = 1'b0;
    if (!r) begin
      m_show = 0;
      m_last = NUM_SRC - 1;
      m_cur  = 0;
      m_din  = '0;
      m_age  = 0;
    end else begin
      if (m_show) m_age++;
`ifdef SRC0_PREEMPT_EN
      pre = m_show && (m_cur != 0) && q[0];
`endif
      if (pre) begin
        load = 1;
        w    = 0;
      end else if (!m_show || m_age >= HOLD) begin
        if (q != 4'b0) begin
          load = 1;
          w    = rrWinner(q, m_last);
        end else begin
          m_show = 0;
        end
      end
      if (load) begin
        t           = d >> (8 * w);
        m_din       = t[7:0];
        m_exp.grant = 4'b0001 << w;
        m_exp.en    = 1'b1;
        m_cur       = w;
        m_last      = w;
        m_show      = 1;
        m_age       = 0;
      end
    end
    m_exp.din  = m_din;
    m_exp.busy = m_show;
    m_exp.cur  = 2'(m_cur);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic [31:0] d);
    @(negedge disp_clk);
    rst_n    = r;
    bus.req  = q;
    bus.data = d;
    @(posedge disp_clk);
    modelStep(r, q, d);
    #1;
  endtask

  task automatic checkOutput(input string name, input obs_t exp);
    obs_t act;
    act = mkObs(bus.grant, bus.disp_en, bus.disp_din, bus.busy, bus.cur_src);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b en=%b din=%h busy=%b cur=%0d, want grant=%b en=%b din=%h busy=%b cur=%0d",
               name, act.grant, act.en, act.din, act.busy, act.cur,
               exp.grant, exp.en, exp.din, exp.busy, exp.cur);
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    int          order[3];
    logic [3:0]  g_exp;
    logic        r;
    logic [3:0]  q;
    logic [31:0] d;

    bus.req  = '0;
    bus.data = '0;
    order    = '{0, 1, 3};

    // Reset, single source 2 (-37 = DB) held then dropped, then a one-cycle request from source 0.
    vecs[0]  = mkVec(0, 4'hF, mkObs(4'h0, 0, 8'h00, 0, 2'd0));
    vecs[1]  = mkVec(0, 4'hF, mkObs(4'h0, 0, 8'h00, 0, 2'd0));
    vecs[2]  = mkVec(1, 4'h4, mkObs(4'h4, 1, 8'hDB, 1, 2'd2));
    vecs[3]  = mkVec(1, 4'h4, mkObs(4'h0, 0, 8'hDB, 1, 2'd2));
    vecs[4]  = mkVec(1, 4'h4, mkObs(4'h0, 0, 8'hDB, 1, 2'd2));
    vecs[5]  = mkVec(1, 4'h4, mkObs(4'h0, 0, 8'hDB, 1, 2'd2));
    vecs[6]  = mkVec(1, 4'h4, mkObs(4'h4, 1, 8'hDB, 1, 2'd2));
    vecs[7]  = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'hDB, 1, 2'd2));
    vecs[8]  = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'hDB, 1, 2'd2));
    vecs[9]  = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'hDB, 1, 2'd2));
    vecs[10] = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'hDB, 0, 2'd2));
    vecs[11] = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'hDB, 0, 2'd2));
    vecs[12] = mkVec(1, 4'h1, mkObs(4'h1, 1, 8'h11, 1, 2'd0));
    vecs[13] = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'h11, 1, 2'd0));
    vecs[14] = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'h11, 1, 2'd0));
    vecs[15] = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'h11, 1, 2'd0));
    vecs[16] = mkVec(1, 4'h0, mkObs(4'h0, 0, 8'h11, 0, 2'd0));

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].req, DATA);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    $display("[TB] round robin with req=1011");
    applyStimulus(0, 4'hF, DATA);
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1, 4'b1011, DATA);
      g_exp = (c % 4 == 0) ? (4'b0001 << order[(c / 4) % 3]) : 4'b0000;
      checkValue($sformatf("rr_grant%0d", c), {4'b0, bus.grant}, {4'b0, g_exp});
    end

    $display("[TB] reset in the middle of a hold");
    applyStimulus(0, 4'h0, DATA);
    applyStimulus(1, 4'b0010, DATA);
    checkOutput("midrst_load", mkObs(4'b0010, 1, 8'h22, 1, 2'd1));
    applyStimulus(1, 4'b0010, DATA);
    applyStimulus(0, 4'b1111, DATA);
    checkOutput("midrst_reset", mkObs(4'h0, 0, 8'h00, 0, 2'd0));
    applyStimulus(1, 4'b0100, DATA);
    checkOutput("midrst_after", mkObs(4'b0100, 1, 8'hDB, 1, 2'd2));

    $display("[TB] source 0 request while source 3 holds");
    applyStimulus(0, 4'h0, DATA);
    applyStimulus(1, 4'b1000, DATA);
    checkOutput("pre_src3", mkObs(4'b1000, 1, 8'h44, 1, 2'd3));
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 4'b1001, DATA);
`ifdef SRC0_PREEMPT_EN
      g_exp = (k == 1) ? 4'b0001 : 4'b0000;
`else
      g_exp = (k == 4) ? 4'b0001 : 4'b0000;
`endif
      checkValue($sformatf("pre_grant%0d", k), {4'b0, bus.grant}, {4'b0, g_exp});
    end

    $display("[TB] randomized traffic against reference model");
    applyStimulus(0, 4'h0, DATA);
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 59) != 0);
      q = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) q = 4'h0;
      d = $urandom;
      applyStimulus(r, q, d);
      checkOutput($sformatf("rand%0d", n), m_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
